// File: rtl/kernel_dot_product.sv
// Signed dot product of a stored kernel vector against streamed activation vectors.
// Two-stage pipeline (masked products, then adder tree) with valid/ready handshakes on both sides.
module kernel_dot_product #(
  parameter int MaxWidth  = 9,
  parameter int DataWidth = 8,
  parameter int AccWidth  = 2 * DataWidth + 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          kernelLoad,
  input  logic [MaxWidth*DataWidth-1:0] kernelIn,
  input  logic [4:0]                    kernelWidth,
  input  logic                          actValid,
  output logic                          actReady,
  input  logic [MaxWidth*DataWidth-1:0] actIn,
  output logic                          resValid,
  input  logic                          resReady,
  output logic signed [AccWidth-1:0]    result,
  output logic                          busy
);
  localparam int ProdWidth = 2 * DataWidth;
  localparam logic [4:0] MaxLanes = 5'(MaxWidth);

  logic [MaxWidth*DataWidth-1:0] kernelReg;
  logic [4:0]                    laneCnt;
  logic                          kernelLoaded;
  logic                          advance;
  logic                          accept;
  logic signed [ProdWidth-1:0]   prodNext [MaxWidth];
  logic signed [ProdWidth-1:0]   prod_p1  [MaxWidth];
  logic                          vld_p1;
  logic signed [AccWidth-1:0]    sum_p1;

  function automatic logic [4:0] clampLanes(input logic [4:0] w);
    return (w > MaxLanes) ? MaxLanes : w;
  endfunction

  function automatic logic signed [ProdWidth-1:0] laneProduct(
    input logic signed [DataWidth-1:0] k,
    input logic signed [DataWidth-1:0] a,
    input logic                        enable
  );
    return enable ? ProdWidth'(k) * ProdWidth'(a) : '0;
  endfunction

  function automatic logic signed [AccWidth-1:0] signExtend(input logic signed [ProdWidth-1:0] p);
    return {{(AccWidth - ProdWidth){p[ProdWidth-1]}}, p};
  endfunction

  assign advance  = !resValid || resReady;
  assign actReady = kernelLoaded && advance && !kernelLoad;
  assign accept   = actValid && actReady;
  assign busy     = vld_p1 || resValid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kernelReg    <= '0;
      laneCnt      <= '0;
      kernelLoaded <= 1'b0;
    end else if (kernelLoad) begin
      kernelReg    <= kernelIn;
      laneCnt      <= clampLanes(kernelWidth);
      kernelLoaded <= 1'b1;
    end
  end

  // Stage 0 -> 1: masked lane products of the accepted vector
  always_comb begin
    for (int i = 0; i < MaxWidth; i++) begin
      prodNext[i] = laneProduct(kernelReg[i*DataWidth +: DataWidth],
                                actIn[i*DataWidth +: DataWidth],
                                i < int'(laneCnt));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p1 <= prodNext;
    end
  end

  // Stage 1 -> 2: adder tree into the output register
  always_comb begin
    sum_p1 = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      sum_p1 = sum_p1 + signExtend(prod_p1[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resValid <= 1'b0;
      result   <= '0;
    end else if (advance) begin
      resValid <= vld_p1;
      if (vld_p1) begin
        result <= sum_p1;
      end
    end
  end
endmodule

// File: tb/tb_kernel_dot_product.sv
// Randomized and directed bench for kernel_dot_product, scored against a queue-based
// model that computes each dot product from the kernel in force when the vector was accepted.
module tb_kernel_dot_product;
  localparam int Lanes = 9;
  localparam int DW    = 8;
  localparam int AW    = 20;
  localparam int VW    = Lanes * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          kernelLoad = 1'b0;
  logic [VW-1:0] kernelIn = '0;
  logic [4:0]    kernelWidth = '0;
  logic          actValid = 1'b0;
  logic          actReady;
  logic [VW-1:0] actIn = '0;
  logic          resValid;
  logic          resReady = 1'b1;
  logic [AW-1:0] result;
  logic          busy;

  kernel_dot_product #(.MaxWidth(Lanes), .DataWidth(DW), .AccWidth(AW)) dut (
    .clk(clk), .rst(rst), .kernelLoad(kernelLoad), .kernelIn(kernelIn),
    .kernelWidth(kernelWidth), .actValid(actValid), .actReady(actReady),
    .actIn(actIn), .resValid(resValid), .resReady(resReady), .result(result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     modelKernel [Lanes];
  int     modelLanes  = 0;
  bit     modelLoaded = 1'b0;
  longint expQ [$];
  bit     stallPrev = 1'b0;
  longint heldResult = 0;

  task automatic checkVal(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint resultVal();
    return longint'($signed(result));
  endfunction

  function automatic longint modelDot(input logic [VW-1:0] act);
    longint s = 0;
    for (int i = 0; i < modelLanes; i++) begin
      s += longint'(modelKernel[i]) * longint'($signed(act[i*DW +: DW]));
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] fillLanes(input int v);
    logic [VW-1:0] r;
    logic [DW-1:0] e;
    e = DW'(v);
    for (int i = 0; i < Lanes; i++) r[i*DW +: DW] = e;
    return r;
  endfunction

  // Monitor: scoreboard, hold-while-stalled, busy and ready rules
  always @(negedge clk) begin
    if (rst) begin
      checkVal("busy", longint'(busy), longint'(expQ.size() != 0));
      checkVal("actReady", longint'(actReady),
               longint'(modelLoaded && (!resValid || resReady) && !kernelLoad));
      if (actValid && actReady) expQ.push_back(modelDot(actIn));
      if (resValid) begin
        if (stallPrev) checkVal("holdResult", resultVal(), heldResult);
        if (resReady) begin
          if (expQ.size() == 0) checkVal("spuriousResult", resultVal(), -1);
          else checkVal("result", resultVal(), expQ.pop_front());
          stallPrev = 1'b0;
        end else begin
          stallPrev  = 1'b1;
          heldResult = resultVal();
        end
      end else begin
        if (stallPrev) checkVal("holdValid", 0, 1);
        stallPrev = 1'b0;
      end
    end
  end

  task automatic setKernelModel(input logic [VW-1:0] k, input int w);
    for (int i = 0; i < Lanes; i++) modelKernel[i] = int'($signed(k[i*DW +: DW]));
    modelLanes  = (w > Lanes) ? Lanes : w;
    modelLoaded = 1'b1;
  endtask

  task automatic loadKernel(input logic [VW-1:0] k, input int w);
    kernelIn    = k;
    kernelWidth = 5'(w);
    kernelLoad  = 1'b1;
    setKernelModel(k, w);
    @(negedge clk);
    checkVal("loadCycleReady", longint'(actReady), 0);
    @(posedge clk); #1;
    kernelLoad = 1'b0;
  endtask

  task automatic sendVec(input logic [VW-1:0] act);
    bit acc;
    int n = 0;
    actValid = 1'b1;
    actIn    = act;
    forever begin
      @(negedge clk);
      acc = actReady;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        checkVal("acceptTimeout", 0, 1);
        break;
      end
    end
    actValid = 1'b0;
  endtask

  task automatic expectResult(input string tag, input longint exp);
    int n = 0;
    while (!(resValid && resReady) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal(tag, resultVal(), exp);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    expQ.delete();
    stallPrev   = 1'b0;
    modelLoaded = 1'b0;
    modelLanes  = 0;
    #1;
    checkVal("rstResValid", longint'(resValid), 0);
    checkVal("rstBusy", longint'(busy), 0);
    checkVal("rstActReady", longint'(actReady), 0);
    checkVal("rstResult", resultVal(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL globalTimeout observed 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    logic [VW-1:0] ramp;
    for (int i = 0; i < Lanes; i++) ramp[i*DW +: DW] = DW'(i + 1);

    #3;
    doReset();

    // No kernel loaded: nothing accepted, nothing produced; a load pulse does not accept
    actValid = 1'b1;
    actIn    = ramp;
    repeat (4) begin
      @(negedge clk);
      checkVal("noKernelReady", longint'(actReady), 0);
      checkVal("noKernelValid", longint'(resValid), 0);
      @(posedge clk); #1;
    end
    loadKernel(fillLanes(1), 9);
    actValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic: all-ones kernel, ramp activation, latency of two cycles
    sendVec(ramp);
    @(negedge clk);
    checkVal("lat1Valid", longint'(resValid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("lat2Valid", longint'(resValid), 1);
    checkVal("basic45", resultVal(), 45);
    @(posedge clk); #1;

    // Signed values with lane masking and width clamping
    loadKernel(fillLanes(-128), 3);
    sendVec(fillLanes(127));
    expectResult("signedW3", -48768);
    loadKernel(fillLanes(-128), 12);
    sendVec(fillLanes(127));
    expectResult("clampW12", -146304);
    loadKernel(fillLanes(5), 0);
    sendVec(ramp);
    expectResult("width0", 0);

    // Backpressure mid-stream
    loadKernel(fillLanes(1), 9);
    fork
      begin
        for (int v = 0; v < 4; v++) sendVec(fillLanes(v + 2));
      end
      begin
        repeat (2) @(posedge clk);
        #2 resReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("stallReady", longint'(actReady), 0);
        checkVal("stallValid", longint'(resValid), 1);
        @(posedge clk);
        #2 resReady = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checkVal("bpDrained", longint'(expQ.size()), 0);

    // Kernel swap with an old-kernel vector still in S1
    loadKernel(fillLanes(2), 9);
    sendVec(fillLanes(1));
    loadKernel(fillLanes(3), 9);
    sendVec(fillLanes(1));
    repeat (3) @(posedge clk);
    #1;
    checkVal("swapDrained", longint'(expQ.size()), 0);

    // Reset with two vectors in flight
    sendVec(ramp);
    sendVec(fillLanes(7));
    doReset();
    actValid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkVal("postRstReady", longint'(actReady), 0);
      checkVal("postRstValid", longint'(resValid), 0);
      @(posedge clk); #1;
    end
    actValid = 1'b0;

    // Randomized traffic with random kernel reloads and backpressure
    loadKernel(fillLanes(1), 9);
    for (int c = 0; c < 600; c++) begin
      resReady = ($urandom_range(0, 3) != 0);
      actValid = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < Lanes; i++) actIn[i*DW +: DW] = DW'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        logic [VW-1:0] k;
        int w;
        for (int i = 0; i < Lanes; i++) k[i*DW +: DW] = DW'($urandom);
        w = $urandom_range(0, 31);
        kernelIn    = k;
        kernelWidth = 5'(w);
        kernelLoad  = 1'b1;
        setKernelModel(k, w);
      end else begin
        kernelLoad = 1'b0;
      end
      @(posedge clk); #1;
    end
    kernelLoad = 1'b0;
    actValid   = 1'b0;
    resReady   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkVal("finalDrained", longint'(expQ.size()), 0);
    checkVal("finalBusy", longint'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
